// File: rtl/algo_2rw_b740_req_sched.sv
`default_nettype none
// ============================================================================
// algo_2rw_b740_req_sched : two-port request scheduler for a 2RW memory wrapper
//   with same-address hazard serialization and credit-based response FIFOs.
// Revision : 1.0
// ============================================================================
module algo_2rw_b740_req_sched #(
    parameter int WIDTH    = 32,
    parameter int BITADDR  = 13,
    parameter int REQDEPTH = 4,
    parameter int BITREQD  = 2,
    parameter int RSPDEPTH = 4,
    parameter int BITRSPD  = 2,
    parameter int RDLAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_vld,
    output logic [1:0]           req_rdy,
    input  logic [1:0]           req_wr,
    input  logic [2*BITADDR-1:0] req_addr,
    input  logic [2*WIDTH-1:0]   req_din,
    input  logic [2*WIDTH-1:0]   req_bw,
    output logic [1:0]           rw_read,
    output logic [1:0]           rw_write,
    output logic [2*BITADDR-1:0] rw_addr,
    output logic [2*WIDTH-1:0]   rw_din,
    output logic [2*WIDTH-1:0]   rw_bw,
    input  logic [1:0]           rw_vld,
    input  logic [2*WIDTH-1:0]   rw_dout,
    output logic [1:0]           rsp_vld,
    input  logic [1:0]           rsp_rdy,
    output logic [2*WIDTH-1:0]   rsp_dout
);

    localparam int ENTW = 1 + BITADDR + 2 * WIDTH;
    localparam int DRW  = (RDLAT > 0) ? $clog2(RDLAT + 1) : 1;
    localparam logic [DRW-1:0]     DRAIN_INIT = RDLAT[DRW-1:0];
    localparam logic [BITRSPD+1:0] RSP_LIMIT  = RSPDEPTH[BITRSPD+1:0];

    logic [DRW-1:0]          drain_cnt;
    logic                    drain_done;
    logic                    draining;
    logic                    rr;
    logic                    conflict;
    logic [1:0]              eligible;
    logic [1:0]              head_wr;
    logic [1:0][BITADDR-1:0] head_addr;
    logic [1:0]              issue;

    // Returns still in the wrapper pipe at reset time arrive during the drain and are dropped.
    assign draining = (drain_cnt != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            drain_cnt  <= DRAIN_INIT;
            drain_done <= 1'b0;
        end else begin
            if (draining) begin
                drain_cnt <= drain_cnt - DRW'(1);
            end
            drain_done <= !draining;
        end
    end

    always_comb begin
        conflict = eligible[0] && eligible[1] &&
                   (head_addr[0] == head_addr[1]) && (head_wr[0] || head_wr[1]);
        issue = eligible;
        if (conflict) begin
            issue = rr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr <= 1'b0;
        end else if (conflict) begin
            rr <= ~rr;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [ENTW-1:0]    req_mem [REQDEPTH];
        logic [BITREQD:0]   req_wp;
        logic [BITREQD:0]   req_rp;
        logic [BITREQD:0]   req_cnt;
        logic [ENTW-1:0]    head;
        logic               req_push;
        logic               req_nonempty;
        logic [WIDTH-1:0]   rsp_mem [RSPDEPTH];
        logic [BITRSPD:0]   rsp_wp;
        logic [BITRSPD:0]   rsp_rp;
        logic [BITRSPD:0]   rsp_cnt;
        logic [BITRSPD:0]   inflight;
        logic [BITRSPD+1:0] credit_used;
        logic               rsp_nonempty;
        logic               rsp_push;
        logic               rsp_pop;
        logic               rd_issue;
        logic               rd_q;
        logic               wr_q;
        logic [BITADDR-1:0] addr_q;
        logic [WIDTH-1:0]   din_q;
        logic [WIDTH-1:0]   bw_q;

        assign req_cnt      = req_wp - req_rp;
        assign req_nonempty = (req_cnt != '0);
        assign req_rdy[p]   = drain_done && !req_cnt[BITREQD];
        assign req_push     = req_vld[p] && req_rdy[p];
        assign head         = req_mem[req_rp[BITREQD-1:0]];
        assign head_wr[p]   = head[ENTW-1];
        assign head_addr[p] = head[ENTW-2 -: BITADDR];

        // A read may only issue if its response is guaranteed a slot in the response FIFO.
        assign credit_used  = {1'b0, inflight} + {1'b0, rsp_cnt};
        assign eligible[p]  = req_nonempty && (head_wr[p] || (credit_used < RSP_LIMIT));
        assign rd_issue     = issue[p] && !head_wr[p];

        always_ff @(posedge clk) begin
            if (req_push) begin
                req_mem[req_wp[BITREQD-1:0]] <= {req_wr[p], req_addr[p*BITADDR +: BITADDR],
                                                 req_din[p*WIDTH +: WIDTH], req_bw[p*WIDTH +: WIDTH]};
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                req_wp <= '0;
                req_rp <= '0;
            end else begin
                if (req_push) req_wp <= req_wp + 1'b1;
                if (issue[p]) req_rp <= req_rp + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                rd_q   <= 1'b0;
                wr_q   <= 1'b0;
                addr_q <= '0;
                din_q  <= '0;
                bw_q   <= '0;
            end else begin
                rd_q <= rd_issue;
                wr_q <= issue[p] && head_wr[p];
                if (issue[p]) begin
                    addr_q <= head[ENTW-2 -: BITADDR];
                    din_q  <= head_wr[p] ? head[2*WIDTH-1 -: WIDTH] : '0;
                    bw_q   <= head_wr[p] ? head[WIDTH-1:0] : '0;
                end
            end
        end

        assign rw_read[p]                    = rd_q;
        assign rw_write[p]                   = wr_q;
        assign rw_addr[p*BITADDR +: BITADDR] = addr_q;
        assign rw_din[p*WIDTH +: WIDTH]      = din_q;
        assign rw_bw[p*WIDTH +: WIDTH]       = bw_q;

        assign rsp_cnt      = rsp_wp - rsp_rp;
        assign rsp_nonempty = (rsp_cnt != '0);
        assign rsp_push     = rw_vld[p] && !draining;
        assign rsp_pop      = rsp_nonempty && rsp_rdy[p];
        assign rsp_vld[p]   = rsp_nonempty;
        assign rsp_dout[p*WIDTH +: WIDTH] = rsp_nonempty ? rsp_mem[rsp_rp[BITRSPD-1:0]] : '0;

        always_ff @(posedge clk) begin
            if (rsp_push) begin
                rsp_mem[rsp_wp[BITRSPD-1:0]] <= rw_dout[p*WIDTH +: WIDTH];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                rsp_wp   <= '0;
                rsp_rp   <= '0;
                inflight <= '0;
            end else begin
                if (rsp_push) rsp_wp <= rsp_wp + 1'b1;
                if (rsp_pop)  rsp_rp <= rsp_rp + 1'b1;
                if (rd_issue && !rsp_push) begin
                    inflight <= inflight + 1'b1;
                end else if (!rd_issue && rsp_push) begin
                    inflight <= inflight - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_algo_2rw_b740_req_sched.sv
`default_nettype none
// Directed bench for algo_2rw_b740_req_sched driving a behavioural 2RW memory
// with a one-cycle read return; memory words default to 0xC0DE0000 | addr.
module tb_algo_2rw_b740_req_sched;
    localparam int WIDTH   = 32;
    localparam int BITADDR = 13;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req_vld;
    logic [1:0]           req_rdy;
    logic [1:0]           req_wr;
    logic [2*BITADDR-1:0] req_addr;
    logic [2*WIDTH-1:0]   req_din;
    logic [2*WIDTH-1:0]   req_bw;
    logic [1:0]           rw_read;
    logic [1:0]           rw_write;
    logic [2*BITADDR-1:0] rw_addr;
    logic [2*WIDTH-1:0]   rw_din;
    logic [2*WIDTH-1:0]   rw_bw;
    logic [1:0]           rw_vld = '0;
    logic [2*WIDTH-1:0]   rw_dout = '0;
    logic [1:0]           rsp_vld;
    logic [1:0]           rsp_rdy;
    logic [2*WIDTH-1:0]   rsp_dout;

    int n_checks = 0;
    int n_errors = 0;

    algo_2rw_b740_req_sched #(
        .WIDTH(WIDTH), .BITADDR(BITADDR), .REQDEPTH(4), .BITREQD(2),
        .RSPDEPTH(4), .BITRSPD(2), .RDLAT(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
        .req_din(req_din), .req_bw(req_bw),
        .rw_read(rw_read), .rw_write(rw_write), .rw_addr(rw_addr), .rw_din(rw_din), .rw_bw(rw_bw),
        .rw_vld(rw_vld), .rw_dout(rw_dout),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dout(rsp_dout)
    );

    always #5 clk = ~clk;

    // ---------------- memory model and protocol monitors ----------------
    logic [WIDTH-1:0]   mem [8192];
    bit                 written [8192];
    logic [BITADDR-1:0] ma;
    logic [WIDTH-1:0]   mold;
    int rd_cnt1 = 0;
    int run11 = 0;
    int max_run11 = 0;
    int proto_err = 0;
    int hazard_err = 0;

    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            ma = rw_addr[p*BITADDR +: BITADDR];
            mold = written[ma] ? mem[ma] : (32'hC0DE_0000 | 32'(ma));
            rw_vld[p] <= rw_read[p];
            if (rw_read[p]) rw_dout[p*WIDTH +: WIDTH] <= mold;
            if (rw_write[p]) begin
                mem[ma] <= (mold & ~rw_bw[p*WIDTH +: WIDTH]) | (rw_din[p*WIDTH +: WIDTH] & rw_bw[p*WIDTH +: WIDTH]);
                written[ma] <= 1'b1;
            end
        end
        if (rw_read[1]) rd_cnt1 = rd_cnt1 + 1;
        if ((rw_read & rw_write) != 2'b00) proto_err = proto_err + 1;
        if ((rw_read[0] | rw_write[0]) && (rw_read[1] | rw_write[1]) &&
            (rw_addr[BITADDR-1:0] == rw_addr[2*BITADDR-1:BITADDR]) && (rw_write != 2'b00))
            hazard_err = hazard_err + 1;
        if (rw_read == 2'b11) run11 = run11 + 1;
        else run11 = 0;
        if (run11 > max_run11) max_run11 = run11;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- response scoreboard ----------------
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int unexp_cnt = 0;

    always @(negedge clk) begin
        if (rsp_vld[0] && rsp_rdy[0]) begin
            if (q0.size() == 0) unexp_cnt = unexp_cnt + 1;
            else check_eq("rsp0_data", rsp_dout[WIDTH-1:0], q0.pop_front());
        end
        if (rsp_vld[1] && rsp_rdy[1]) begin
            if (q1.size() == 0) unexp_cnt = unexp_cnt + 1;
            else check_eq("rsp1_data", rsp_dout[2*WIDTH-1:WIDTH], q1.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p, input logic wr, input logic [BITADDR-1:0] a,
                        input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] bw);
        int budget = 50;
        req_wr[p] = wr;
        req_addr[p*BITADDR +: BITADDR] = a;
        req_din[p*WIDTH +: WIDTH] = d;
        req_bw[p*WIDTH +: WIDTH] = bw;
        req_vld[p] = 1'b1;
        while (!req_rdy[p] && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check_eq("send_timeout", {63'd0, req_rdy[p]}, 64'd1);
        tick();
        req_vld[p] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000ns");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int stalls;
        int budget;
        int rsp_seen;
        rst = 1'b0; req_vld = '0; req_wr = '0; req_addr = '0; req_din = '0; req_bw = '0;
        rsp_rdy = 2'b11;
        tick(); tick();
        check_eq("rst_req_rdy", req_rdy, 0);
        check_eq("rst_strobes", {rw_read, rw_write, rsp_vld}, 0);
        check_eq("rst_rw_addr", rw_addr, 0);
        check_eq("rst_rsp_dout", rsp_dout, 0);
        rst = 1'b1;
        tick();
        check_eq("drain_req_rdy", req_rdy, 0);
        tick();
        check_eq("ready_after_drain", req_rdy, 2'b11);

        // Read after write on port 0
        q0.push_back(32'hDEAD_BEEF);
        req_vld = 2'b01; req_wr = 2'b01; req_addr[BITADDR-1:0] = 13'd5;
        req_din[WIDTH-1:0] = 32'hDEAD_BEEF; req_bw[WIDTH-1:0] = 32'hFFFF_FFFF;
        tick();
        req_wr = 2'b00;
        tick();
        req_vld = 2'b00;
        check_eq("raw_write_strobe", {rw_read, rw_write}, 4'b0001);
        check_eq("raw_write_addr", rw_addr[BITADDR-1:0], 13'd5);
        check_eq("raw_write_din", rw_din[WIDTH-1:0], 32'hDEAD_BEEF);
        tick();
        check_eq("raw_read_strobe", {rw_read, rw_write}, 4'b0100);
        check_eq("raw_read_din_zero", {rw_din[WIDTH-1:0], rw_bw[WIDTH-1:0]}, 0);
        tick();
        check_eq("raw_rsp_not_yet", rsp_vld, 2'b00);
        tick();
        check_eq("raw_rsp_vld", rsp_vld, 2'b01);
        check_eq("raw_rsp_dout", rsp_dout[WIDTH-1:0], 32'hDEAD_BEEF);
        tick();

        // Same-address write/write, twice: rr alternates the winner
        for (int r = 0; r < 2; r++) begin
            req_vld = 2'b11; req_wr = 2'b11;
            req_addr = {13'h10, 13'h10};
            req_din = {32'h2222_2222, 32'h1111_1111};
            req_bw = '1;
            tick();
            req_vld = 2'b00;
            tick();
            check_eq(r == 0 ? "ww_first_p0" : "ww_first_p1", rw_write, r == 0 ? 2'b01 : 2'b10);
            tick();
            check_eq(r == 0 ? "ww_second_p1" : "ww_second_p0", rw_write, r == 0 ? 2'b10 : 2'b01);
            if (r == 0) check_eq("ww_p1_din", rw_din[2*WIDTH-1:WIDTH], 32'h2222_2222);
            tick();
        end

        // Port0 read vs port1 write on addr 7: rr=0 so the read goes first
        q0.push_back(32'hC0DE_0007);
        req_vld = 2'b11; req_wr = 2'b10;
        req_addr = {13'd7, 13'd7};
        req_din = {32'hA5A5_A5A5, 32'h0};
        req_bw = {32'hFFFF_FFFF, 32'h0};
        tick();
        req_vld = 2'b00;
        tick();
        check_eq("rw7_first_read", {rw_read, rw_write}, 4'b0100);
        check_eq("rw7_first_addr", rw_addr[BITADDR-1:0], 13'd7);
        tick();
        check_eq("rw7_second_write", {rw_read, rw_write}, 4'b0010);
        check_eq("rw7_second_addr", rw_addr[2*BITADDR-1:BITADDR], 13'd7);
        tick();
        check_eq("rw7_rsp", {rsp_vld, rsp_dout[WIDTH-1:0]}, {2'b01, 32'hC0DE_0007});
        tick(); tick();

        // Credit back-pressure on port 1
        rsp_rdy[1] = 1'b0;
        base = rd_cnt1;
        for (int k = 0; k < 8; k++) begin
            q1.push_back(32'hC0DE_0020 + k);
            send(1, 1'b0, 13'(32'h20 + k), 32'h0, 32'h0);
        end
        check_eq("credit_fifo_full", req_rdy[1], 1'b0);
        repeat (8) tick();
        check_eq("credit_read_pulses", rd_cnt1 - base, 4);
        check_eq("credit_still_full", req_rdy[1], 1'b0);
        check_eq("credit_rsp_held", rsp_vld[1], 1'b1);
        rsp_rdy[1] = 1'b1;
        budget = 60;
        while (q1.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        repeat (4) tick();
        check_eq("credit_all_rsp", q1.size(), 0);
        check_eq("credit_total_reads", rd_cnt1 - base, 8);

        // Full rate on both ports
        stalls = 0;
        for (int k = 0; k < 16; k++) begin
            q0.push_back(32'hC0DE_0100 + k);
            q1.push_back(32'hC0DE_0200 + k);
            req_vld = 2'b11; req_wr = 2'b00;
            req_addr = {13'(32'h200 + k), 13'(32'h100 + k)};
            if (req_rdy != 2'b11) stalls++;
            tick();
        end
        req_vld = 2'b00;
        repeat (10) tick();
        check_eq("fr_no_stall", stalls, 0);
        check_eq("fr_read_run", max_run11, 16);
        check_eq("fr_rsp_done", q0.size() + q1.size(), 0);

        // Reset while reads are in flight
        req_vld = 2'b01; req_wr = 2'b00;
        req_addr[BITADDR-1:0] = 13'h30; tick();
        req_addr[BITADDR-1:0] = 13'h31; tick();
        req_addr[BITADDR-1:0] = 13'h32; tick();
        check_eq("prerst_read_active", rw_read, 2'b01);
        req_vld = 2'b00;
        rst = 1'b0;
        tick();
        check_eq("mrst_strobes", {req_rdy, rw_read, rw_write, rsp_vld}, 0);
        check_eq("mrst_rw_addr", rw_addr, 0);
        check_eq("mrst_rw_din_bw", {rw_din, rw_bw}, 0);
        check_eq("mrst_rsp_dout", rsp_dout, 0);
        rst = 1'b1;
        tick();
        check_eq("mrst_drain_rdy", req_rdy, 2'b00);
        tick();
        check_eq("mrst_ready", req_rdy, 2'b11);
        rsp_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_vld != 2'b00 || rw_read != 2'b00) rsp_seen++;
            tick();
        end
        check_eq("mrst_no_stale", rsp_seen, 0);

        check_eq("rw_exclusive", proto_err, 0);
        check_eq("hazard_serialized", hazard_err, 0);
        check_eq("unexpected_rsp", unexp_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
